// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side PRBS checker. Seeds a local LFSR copy from the
// incoming bit stream, verifies a run of correct predictions before declaring
// lock, then counts bit errors and drops lock when errors cluster in a window.
module lfsr_checker #(
  parameter int DEPTH       = 8,
  parameter int LOCK_COUNT  = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dir,
  input  logic [DEPTH-1:0] taps,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int FILL_W  = $clog2(DEPTH) + 1;
  localparam int MATCH_W = $clog2(LOCK_COUNT) + 1;
  localparam int WBITS_W = $clog2(WINDOW) + 1;
  localparam int WERRS_W = $clog2(LOSS_THRESH) + 1;

  localparam logic [FILL_W-1:0]  FILL_END  = FILL_W'(DEPTH);
  localparam logic [MATCH_W-1:0] MATCH_END = MATCH_W'(LOCK_COUNT);
  localparam logic [WBITS_W-1:0] WBITS_END = WBITS_W'(WINDOW);
  localparam logic [WERRS_W-1:0] WERRS_END = WERRS_W'(LOSS_THRESH);

  typedef enum logic [1:0] {
    ST_SEED   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t              r_state;
  logic [DEPTH-1:0]    r_lfsr;
  logic [FILL_W-1:0]   r_fill;
  logic [MATCH_W-1:0]  r_match;
  logic [WBITS_W-1:0]  r_win_bits;
  logic [WERRS_W-1:0]  r_win_errs;
  logic [ERR_W-1:0]    r_err_count;
  logic                r_err_pulse;
  logic                r_locked;

  state_t              w_state_nxt;
  logic [DEPTH-1:0]    w_lfsr_nxt;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic [MATCH_W-1:0]  w_match_nxt;
  logic [WBITS_W-1:0]  w_win_bits_nxt;
  logic [WERRS_W-1:0]  w_win_errs_nxt;
  logic [ERR_W-1:0]    w_err_count_nxt;

  logic                w_pred;
  logic                w_mismatch;
  logic                w_lfsr_zero;
  logic                w_shift_bit;
  logic [DEPTH-1:0]    w_shifted;
  logic                w_count_err;
  logic [FILL_W-1:0]   w_fill_inc;
  logic [MATCH_W-1:0]  w_match_inc;
  logic [WBITS_W-1:0]  w_win_bits_inc;
  logic [WERRS_W-1:0]  w_win_errs_inc;

  // Prediction and shift datapath; once locked the register free-runs on its
  // own prediction so a corrupted received bit never pollutes later predictions.
  always_comb begin
    w_pred         = ^(r_lfsr & taps);
    w_mismatch     = bit_in ^ w_pred;
    w_lfsr_zero    = (r_lfsr == '0);
    w_shift_bit    = (r_state == ST_LOCKED) ? w_pred : bit_in;
    w_shifted      = dir ? {r_lfsr[DEPTH-2:0], w_shift_bit}
                         : {w_shift_bit, r_lfsr[DEPTH-1:1]};
    w_count_err    = (r_state == ST_LOCKED) && bit_valid && w_mismatch;
    w_fill_inc     = r_fill + FILL_W'(1);
    w_match_inc    = r_match + MATCH_W'(1);
    w_win_bits_inc = r_win_bits + WBITS_W'(1);
    w_win_errs_inc = r_win_errs + WERRS_W'(1);
  end

  // Next-state and counter updates; everything holds on idle cycles.
  always_comb begin
    w_state_nxt    = r_state;
    w_lfsr_nxt     = r_lfsr;
    w_fill_nxt     = r_fill;
    w_match_nxt    = r_match;
    w_win_bits_nxt = r_win_bits;
    w_win_errs_nxt = r_win_errs;
    if (bit_valid) begin
      case (r_state)
        ST_SEED: begin
          w_lfsr_nxt = w_shifted;
          w_fill_nxt = w_fill_inc;
          if (w_fill_inc == FILL_END) begin
            w_state_nxt = ST_VERIFY;
            w_match_nxt = '0;
          end
        end
        ST_VERIFY: begin
          w_lfsr_nxt = w_shifted;
          // An all-zero register predicts zeros forever, so a stuck-low
          // stream must never be allowed to count toward lock.
          if (!w_mismatch && !w_lfsr_zero) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == MATCH_END) begin
              w_state_nxt    = ST_LOCKED;
              w_win_bits_nxt = '0;
              w_win_errs_nxt = '0;
            end
          end else begin
            w_state_nxt = ST_SEED;
            w_fill_nxt  = '0;
          end
        end
        ST_LOCKED: begin
          w_lfsr_nxt     = w_shifted;
          w_win_bits_nxt = w_win_bits_inc;
          if (w_mismatch) begin
            w_win_errs_nxt = w_win_errs_inc;
          end
          // Loss of lock takes priority over the window rollover.
          if (w_mismatch && (w_win_errs_inc == WERRS_END)) begin
            w_state_nxt = ST_SEED;
            w_fill_nxt  = '0;
          end else if (w_win_bits_inc == WBITS_END) begin
            w_win_bits_nxt = '0;
            w_win_errs_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = ST_SEED;
          w_fill_nxt  = '0;
        end
      endcase
    end
  end

  // Cumulative error counter: saturating, clearable, clear keeps a coincident error.
  always_comb begin
    w_err_count_nxt = r_err_count;
    if (clear_count) begin
      w_err_count_nxt = w_count_err ? ERR_W'(1) : '0;
    end else if (w_count_err && (r_err_count != '1)) begin
      w_err_count_nxt = r_err_count + ERR_W'(1);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_SEED;
      r_lfsr      <= '1;
      r_fill      <= '0;
      r_match     <= '0;
      r_win_bits  <= '0;
      r_win_errs  <= '0;
      r_err_count <= '0;
      r_err_pulse <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_fill      <= w_fill_nxt;
      r_match     <= w_match_nxt;
      r_win_bits  <= w_win_bits_nxt;
      r_win_errs  <= w_win_errs_nxt;
      r_err_count <= w_err_count_nxt;
      r_err_pulse <= w_count_err;
      r_locked    <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign state     = r_state;

endmodule
